// File: rtl/fb_writer_pkg.sv
// Constants and helpers shared by the frame-buffer writer and the panel scanner.
package fb_writer_pkg;

  localparam int PANEL_COLS = 32;
  localparam int PANEL_ROWS = 32;
  localparam int ADDR_W     = 10;
  localparam int PIX_W      = 24;
  localparam int CH_W       = 8;
  localparam int RED_LSB    = 0;
  localparam int GREEN_LSB  = 8;
  localparam int BLUE_LSB   = 16;

  typedef enum logic [1:0] {
    WAIT_SWAP,
    IDLE,
    WRITE,
    SWAP
  } fb_state_t;

  // Each half-panel RAM is addressed as {buffer, row within half, column}.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic       buf_sel,
                                                  input logic [3:0] row,
                                                  input logic [4:0] col);
    return {buf_sel, row, col};
  endfunction

endpackage

// File: rtl/fb_writer_if.sv
// Raster-order pixel stream with valid/ready handshake and start-of-frame marker.
interface fb_writer_if;
  import fb_writer_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic             s_sof;
  logic [PIX_W-1:0] s_data;

  modport master (output s_valid, output s_sof, output s_data, input s_ready);
  modport slave  (input s_valid, input s_sof, input s_data, output s_ready);

endinterface

// File: rtl/fb_writer_scale.sv
// Combinational channel scaler: (ch*brightness + ch) >> 8, so 255 is identity and 0 blanks.
module fb_scale (
  input  logic [7:0] ch,
  input  logic [7:0] brightness,
  output logic [7:0] scaled
);

  logic [15:0] prod;
  logic [15:0] sum;

  assign prod   = 16'(ch) * 16'(brightness);
  assign sum    = prod + 16'(ch);
  assign scaled = 8'(sum >> 8);

endmodule

// File: rtl/fb_writer.sv
// Write side of the double-buffered 32x32 frame memory; stalls at frame end until the
// scanner has switched to the freshly written buffer.
module fb_writer
  import fb_writer_pkg::*;
#(
  parameter int COL_W     = 5,
  parameter int ROW_W     = 5,
  parameter int FRAME_PIX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  fb_writer_if.slave        s,
  input  logic [CH_W-1:0]   brightness,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_en_hi,
  output logic              wr_en_lo,
  output logic              selected_buffer,
  input  logic              actual_buffer,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int CNT_W = COL_W + ROW_W;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

  fb_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic             accept;
  logic             do_write;
  logic [CNT_W-1:0] pix_idx;
  logic [PIX_W-1:0] scaled;

  assign s.s_ready = ready_q;

  fb_scale u_scale_red (
    .ch         (s.s_data[RED_LSB +: CH_W]),
    .brightness (brightness),
    .scaled     (scaled[RED_LSB +: CH_W])
  );

  fb_scale u_scale_green (
    .ch         (s.s_data[GREEN_LSB +: CH_W]),
    .brightness (brightness),
    .scaled     (scaled[GREEN_LSB +: CH_W])
  );

  fb_scale u_scale_blue (
    .ch         (s.s_data[BLUE_LSB +: CH_W]),
    .brightness (brightness),
    .scaled     (scaled[BLUE_LSB +: CH_W])
  );

  // A start-of-frame pixel always lands at position 0, whether starting or resyncing.
  always_comb begin
    accept   = s.s_valid && ready_q;
    pix_idx  = s.s_sof ? '0 : cnt;
    do_write = accept && ((state == WRITE) || s.s_sof);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= WAIT_SWAP;
      cnt             <= '0;
      ready_q         <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      wr_en_hi        <= 1'b0;
      wr_en_lo        <= 1'b0;
      selected_buffer <= 1'b0;
      frame_done      <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      wr_en_hi   <= 1'b0;
      wr_en_lo   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;

      // Always target the buffer the scanner is not showing.
      if (do_write) begin
        wr_addr  <= pack_addr(~selected_buffer,
                              pix_idx[COL_W +: ROW_W-1],
                              pix_idx[COL_W-1:0]);
        wr_data  <= scaled;
        wr_en_hi <= ~pix_idx[CNT_W-1];
        wr_en_lo <= pix_idx[CNT_W-1];
      end

      case (state)
        WAIT_SWAP: begin
          if (actual_buffer == selected_buffer) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            if (s.s_sof) begin
              cnt   <= CNT_W'(1);
              state <= WRITE;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (accept) begin
            if (s.s_sof) begin
              cnt      <= CNT_W'(1);
              sync_err <= 1'b1;
            end else if (cnt == LAST_PIX) begin
              cnt     <= '0;
              state   <= SWAP;
              ready_q <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SWAP: begin
          selected_buffer <= ~selected_buffer;
          frame_done      <= 1'b1;
          state           <= WAIT_SWAP;
        end
        default: begin
          state   <= WAIT_SWAP;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Randomized bench for fb_writer against a frame-position reference model.
module tb_fb_writer;
  import fb_writer_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  brightness;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_en_hi;
  logic        wr_en_lo;
  logic        selected_buffer;
  logic        actual_buffer;
  logic        frame_done;
  logic        sync_err;

  fb_writer_if s_if ();

  fb_writer dut (
    .clk             (clk),
    .rst             (rst),
    .s               (s_if),
    .brightness      (brightness),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_en_hi        (wr_en_hi),
    .wr_en_lo        (wr_en_lo),
    .selected_buffer (selected_buffer),
    .actual_buffer   (actual_buffer),
    .frame_done      (frame_done),
    .sync_err        (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: frame position (-1 = between frames), pending swap and swap wait.
  bit m_sel;
  int m_pos;
  bit m_wait;
  bit m_swap;
  bit m_ready;
  bit last_acc;

  int wr_seen = 0;
  int fd_seen = 0;
  int se_seen = 0;
  logic [9:0] log_addr[$];
  bit         log_lo[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit sof, input logic [23:0] d, input logic [7:0] b);
    s_if.s_valid = v;
    s_if.s_sof   = sof;
    s_if.s_data  = d;
    brightness   = b;
  endtask

  function automatic logic [23:0] ref_scale(input logic [23:0] d, input int b);
    int r, g, bl;
    r  = (int'(d[7:0])   * (b + 1)) / 256;
    g  = (int'(d[15:8])  * (b + 1)) / 256;
    bl = (int'(d[23:16]) * (b + 1)) / 256;
    return {8'(bl), 8'(g), 8'(r)};
  endfunction

  task automatic step();
    bit acc, do_wr, e_fd, e_se;
    int idx;
    logic [9:0]  e_addr;
    logic [23:0] e_data;
    @(posedge clk);
    do_wr = 0; e_fd = 0; e_se = 0; idx = 0; last_acc = 0;
    e_addr = '0; e_data = '0;
    if (!rst) begin
      m_sel = 0; m_pos = -1; m_wait = 1; m_swap = 0; m_ready = 0;
    end else begin
      acc = s_if.s_valid && m_ready;
      last_acc = acc;
      if (m_swap) begin
        m_sel = !m_sel; e_fd = 1; m_swap = 0; m_wait = 1;
      end else if (m_wait) begin
        if (actual_buffer == m_sel) m_wait = 0;
      end else if (acc) begin
        if (s_if.s_sof) begin
          do_wr = 1; idx = 0;
          if (m_pos > 0) e_se = 1;
          m_pos = 1;
        end else if (m_pos < 0) begin
          e_se = 1;
        end else begin
          do_wr = 1; idx = m_pos; m_pos++;
          if (m_pos == 1024) begin m_pos = -1; m_swap = 1; end
        end
      end
      if (do_wr) begin
        e_addr = 10'(((m_sel ? 0 : 1) << 9) | (((idx / 32) % 16) << 5) | (idx % 32));
        e_data = ref_scale(s_if.s_data, int'(brightness));
      end
      m_ready = !m_wait && !m_swap;
    end
    #1;
    if (wr_en_hi || wr_en_lo) begin
      wr_seen++; log_addr.push_back(wr_addr); log_lo.push_back(wr_en_lo);
    end
    if (frame_done) fd_seen++;
    if (sync_err) se_seen++;
    if (!rst) begin
      checkOutput("rst_ready", s_if.s_ready, 0);
      checkOutput("rst_wr_en", {wr_en_hi, wr_en_lo}, 0);
      checkOutput("rst_addr", wr_addr, 0);
      checkOutput("rst_data", wr_data, 0);
      checkOutput("rst_sel", selected_buffer, 0);
      checkOutput("rst_pulses", {frame_done, sync_err}, 0);
    end else begin
      checkOutput("s_ready", s_if.s_ready, m_ready);
      checkOutput("wr_en_hi", wr_en_hi, do_wr && idx < 512);
      checkOutput("wr_en_lo", wr_en_lo, do_wr && idx >= 512);
      checkOutput("frame_done", frame_done, e_fd);
      checkOutput("sync_err", sync_err, e_se);
      checkOutput("selected_buffer", selected_buffer, m_sel);
      if (do_wr) begin
        checkOutput("wr_addr", wr_addr, e_addr);
        checkOutput("wr_data", wr_data, e_data);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, '0, 8'd255);
      step();
    end
  endtask

  // Feeds n accepted pixels; unqualified sof is sprinkled into the gaps.
  task automatic streamPixels(input int n, input bit sof_first, input int valid_pct, input bit rnd);
    int sent = 0;
    int cycles = 0;
    bit v, sof;
    while (sent < n && cycles < n * 4 + 200) begin
      v   = ($urandom_range(99) < valid_pct);
      sof = v ? (sof_first && sent == 0) : 1'($urandom_range(1));
      applyStimulus(v, sof, rnd ? 24'($urandom) : 24'(sent),
                    rnd ? 8'($urandom_range(255)) : 8'd255);
      step();
      if (last_acc) sent++;
      cycles++;
    end
    if (sent < n) checkOutput("stream_timeout", sent, n);
  endtask

  initial begin
    int wr0, fd0, se0;
    bit all_low;
    rst = 0; actual_buffer = 0;
    applyStimulus(0, 0, '0, 8'd255);
    step(); step();
    rst = 1;

    $display("[TB] first frame, data = pixel index");
    streamPixels(1024, 1, 100, 0);
    idle(2);
    checkOutput("f1_pix0_addr", log_addr[0], 10'h200);
    checkOutput("f1_pix0_lo", log_lo[0], 0);
    checkOutput("f1_pix512_addr", log_addr[512], 10'h200);
    checkOutput("f1_pix512_lo", log_lo[512], 1);
    checkOutput("f1_pix1023_addr", log_addr[1023], 10'h3FF);
    checkOutput("f1_sel", selected_buffer, 1);
    checkOutput("f1_ready", s_if.s_ready, 0);
    checkOutput("f1_frame_done", fd_seen, 1);

    $display("[TB] stall while scanner still shows buffer 0");
    wr0 = wr_seen;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1, 1, 24'h123456, 8'd255);
      step();
    end
    checkOutput("stall_writes", wr_seen - wr0, 0);
    actual_buffer = 1;
    applyStimulus(0, 0, '0, 8'd255);
    step();
    checkOutput("swap_ready", s_if.s_ready, 1);
    wr0 = wr_seen;
    streamPixels(1024, 1, 100, 1);
    idle(2);
    all_low = 1;
    for (int i = wr0; i < wr0 + 1024; i++) if (log_addr[i] >= 10'h200) all_low = 0;
    checkOutput("f2_low_half", all_low, 1);
    checkOutput("f2_sel", selected_buffer, 0);

    $display("[TB] orphan pixels, brightness corners, resync");
    actual_buffer = 0;
    idle(1);
    wr0 = wr_seen; se0 = se_seen;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 24'($urandom), 8'd255);
      step();
    end
    checkOutput("orphan_sync_err", se_seen - se0, 3);
    checkOutput("orphan_writes", wr_seen - wr0, 0);
    applyStimulus(1, 1, 24'hFF8001, 8'd255); step();
    checkOutput("bright255", wr_data, 24'hFF8001);
    applyStimulus(1, 0, 24'hFF8001, 8'd128); step();
    checkOutput("bright128", wr_data, 24'h804000);
    applyStimulus(1, 0, 24'hFF8001, 8'd0); step();
    checkOutput("bright0", wr_data, 24'h000000);
    streamPixels(297, 0, 100, 1);
    fd0 = fd_seen;
    applyStimulus(1, 1, 24'($urandom), 8'd255); step();
    checkOutput("resync_err", sync_err, 1);
    checkOutput("resync_addr", wr_addr, 10'h200);
    streamPixels(1022, 0, 100, 1);
    idle(2);
    checkOutput("resync_no_early_done", fd_seen - fd0, 0);
    streamPixels(1, 0, 100, 1);
    idle(2);
    checkOutput("resync_done", fd_seen - fd0, 1);
    checkOutput("f3_sel", selected_buffer, 1);

    $display("[TB] reset in the middle of a frame");
    actual_buffer = 1;
    streamPixels(700, 1, 100, 1);
    rst = 0;
    step(); step();
    rst = 1;
    checkOutput("post_rst_sel", selected_buffer, 0);
    wr0 = wr_seen;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 24'($urandom), 8'd255);
      step();
    end
    checkOutput("post_rst_stall", wr_seen - wr0, 0);
    actual_buffer = 0;

    $display("[TB] full frame with random valid gaps");
    wr0 = wr_seen; fd0 = fd_seen;
    streamPixels(1024, 1, 60, 1);
    idle(2);
    checkOutput("gap_first_addr", log_addr[wr0], 10'h200);
    checkOutput("gap_write_count", wr_seen - wr0, 1024);
    checkOutput("gap_frame_done", fd_seen - fd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write side of the double-buffered 32x32 RGB frame memory that the LED panel scanner reads.
- Accepts a raster-order pixel stream with a valid/ready handshake and applies a global brightness scale.
- Writes each pixel into the top-half or bottom-half RAM at the {buffer, row, col} address used by the scanner.
- At frame end it flips selected_buffer and stalls the stream until the scanner reports that actual_buffer has taken over, so the displayed buffer is never written.

Parameters:
- COL_W, 5, column address width (32 columns).
- ROW_W, 5, row index width (32 rows; bit ROW_W-1 selects the half).
- FRAME_PIX, 1024, pixels per frame (2**(COL_W+ROW_W)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- s_valid  in  1  pixel valid.
- s_ready  out  1  pixel accepted when s_valid && s_ready.
- s_sof  in  1  marks pixel (0,0) of a frame; qualified by s_valid.
- s_data  in  24  {blue[23:16], green[15:8], red[7:0]}.
- brightness  in  8  global scale; 255 passes data unchanged.
- wr_addr  out  10  {target_buffer, row[3:0], col[4:0]}.
- wr_data  out  24  scaled pixel, same channel packing as s_data.
- wr_en_hi  out  1  write strobe for the rows 0-15 RAM (scanner rd_data_hi).
- wr_en_lo  out  1  write strobe for the rows 16-31 RAM (scanner rd_data_lo).
- selected_buffer  out  1  buffer requested for display; goes to the scanner.
- actual_buffer  in  1  buffer the scanner is currently displaying.
- frame_done  out  1  one-cycle pulse when a full frame is committed.
- sync_err  out  1  one-cycle pulse on a dropped pixel or a mid-frame sof.

Behaviour:
- Reset values:
  - s_ready=0, wr_en_hi/lo=0, wr_addr=0, wr_data=0.
  - selected_buffer=0, frame_done=0, sync_err=0.
  - pixel counter=0, state=WAIT_SWAP.
- target_buffer = ~selected_buffer at all times.
- Pixel counter is 10 bits:
  - col = cnt[4:0], row = cnt[9:5].
  - row[4]=0 selects wr_en_hi, row[4]=1 selects wr_en_lo.
  - Address row field is row[3:0].
- Scaling, per channel: out = (ch*brightness + ch) >> 8, using a 16-bit product plus a 9-bit add, truncated to 8 bits. This gives ch unchanged at brightness 255 and 0 at brightness 0.
- Latency: a pixel accepted at cycle N appears on wr_addr/wr_data with exactly one wr_en at N+1. The registers are a single pipeline stage; wr_en is 0 in every other cycle.
- States:
  - WAIT_SWAP: s_ready=0. Go to IDLE when actual_buffer==selected_buffer; an X/unknown actual_buffer holds this state.
  - IDLE: s_ready=1.
    - valid&&sof: write that pixel as cnt=0, set cnt=1, go to WRITE.
    - valid&&!sof: pixel consumed and discarded, sync_err pulse, stay in IDLE.
  - WRITE: s_ready=1. On each accepted pixel, write it and increment cnt.
    - Accepted pixel with sof and cnt!=0: resync. Write it as pixel 0, cnt=1, pulse sync_err, no swap.
    - Accepted pixel with cnt==1023 (last): write it, cnt wraps to 0, go to SWAP.
  - SWAP: s_ready=0, one cycle. Toggle selected_buffer, pulse frame_done, go to WAIT_SWAP.
- The toggle happens the cycle after the last write issues, so the final RAM write always precedes the request.
- No writes are issued to buffer actual_buffer while actual_buffer==selected_buffer is false; this is the stall invariant.
- An s_sof that is not qualified by s_valid is ignored.
- s_valid low in WRITE: hold state and cnt, issue no write.
- Reset mid-frame:
  - cnt, state and outputs return to their reset values.
  - selected_buffer returns to 0 even if it was 1; the partial frame is abandoned.
  - The scanner then follows within one panel frame.
- brightness is sampled at acceptance; changing it mid-frame affects only later pixels.

Decomposition:
- Shared package holds:
  - PANEL_COLS=32, PANEL_ROWS=32, ADDR_W=10, PIX_W=24.
  - Channel bit ranges (RED_LSB=0, GREEN_LSB=8, BLUE_LSB=16).
  - The buffer-address packing helper {buf,row[3:0],col[4:0]}.
- The scanner uses the same constants.
- One sub-module, fb_scale: a combinational 8-bit channel x brightness scaler, instantiated three times.

Test Plan:
- Reset, actual_buffer=0, then stream 1024 pixels, sof on the first, data=cnt:
  - Pixel 0 -> wr_en_hi, wr_addr=0x200.
  - Pixel 512 -> wr_en_lo, wr_addr=0x200.
  - Pixel 1023 -> wr_en_lo, wr_addr=0x3FF.
  - Then frame_done pulses, selected_buffer=1, s_ready=0.
- Hold actual_buffer=0 for 100 cycles -> s_ready stays 0 and no wr_en. Raise actual_buffer=1 -> s_ready=1 next cycle; the next frame writes addresses 0x000-0x1FF.
- brightness=255 with data 0xFF8001 -> wr_data=0xFF8001. brightness=128 -> wr_data=0x804000. brightness=0 -> 0x000000.
- Send 3 pixels without sof in IDLE -> three sync_err pulses and no wr_en.
- Send sof at pixel 300 -> sync_err, that pixel written at 0x200, frame_done only 1024 pixels later.
- Random s_valid gaps over a full frame -> exactly 1024 wr_en, one per accepted pixel, each one cycle after its acceptance.
- Assert reset at pixel 700 -> all outputs at reset values; after release, state is WAIT_SWAP and the next frame restarts at cnt=0.
